// File: rtl/uart_link_pkg.sv
// Shared state encodings and divider helpers for the uart_link endpoint.
package uart_link_pkg;

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

   function automatic int baud_div(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

   // CNT_W = $clog2(DIV); DIV depends on the instance parameters, so the width is derived here.
   function automatic int cnt_w(input int div);
      return $clog2(div);
   endfunction

endpackage

// File: rtl/uart_link_fifo.sv
// Synchronous FIFO with registered full/empty/count; a push while full is accepted
// only when a pop happens in the same cycle, and a pop while empty is ignored.
module uart_link_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             full_q, full_d, empty_q, empty_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             do_push, do_pop;

   always_comb begin
      do_pop   = pop & ~empty_q;
      do_push  = push & (~full_q | do_pop);
      mem_d    = mem_q;
      if (do_push) mem_d[wr_ptr_q] = din;
      wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
      rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
      count_d  = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
      full_d   = (count_d == (PTR_W+1)'(DEPTH));
      empty_d  = (count_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign dout  = empty_q ? '0 : mem_q[rd_ptr_q];
   assign full  = full_q;
   assign empty = empty_q;
   assign count = count_q;

endmodule

// File: rtl/uart_link.sv
// Full-duplex UART endpoint: baud timing, TX/RX FSMs and two FIFOs.
// Define UART_LINK_ECHO_EN to loop every well-framed received character back into the TX FIFO.
module uart_link #(
   parameter int DATA_WIDTH = 8,
   parameter int CLK_HZ     = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                  clk_auto,
   input  logic                  reset_n,
   input  logic                  send,
   input  logic [DATA_WIDTH-1:0] tx_data,
   output logic                  tx_full,
   output logic                  tx_overflow,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   input  logic                  rx_ack,
   output logic                  rx_overrun,
   output logic                  frame_err,
   input  logic                  clr_err,
   input  logic                  UART_RX,
   output logic                  UART_TX
);
   import uart_link_pkg::*;

   localparam int DIV   = baud_div(CLK_HZ, BAUD);
   localparam int CNT_W = cnt_w(DIV);
   localparam int BIT_W = $clog2(DATA_WIDTH);
   localparam int FC_W  = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2 - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

   tx_state_e             tx_state_q, tx_state_d;
   rx_state_e             rx_state_q, rx_state_d;
   logic [CNT_W-1:0]      tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
   logic [BIT_W-1:0]      tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
   logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
   logic                  uart_tx_q, uart_tx_d;
   logic                  send_dly_q, rx_s1_q, rx_s2_q, rx_prev_q;
   logic                  tx_overflow_q, tx_overflow_d, rx_overrun_q, rx_overrun_d;
   logic                  frame_err_q, frame_err_d;

   logic                  host_push, tx_push, tx_pop, tx_empty, echo_drop;
   logic [DATA_WIDTH-1:0] tx_din, tx_fifo_dout;
   logic [FC_W-1:0]       tx_count, rx_count;
   logic                  rx_push, rx_ferr, rx_pop, rx_full, rx_empty;
`ifdef UART_LINK_ECHO_EN
   logic                  pend_q, pend_d;
   logic [DATA_WIDTH-1:0] pend_data_q, pend_data_d;
`endif

   assign host_push = send & ~send_dly_q;
   assign rx_pop    = rx_ack & ~rx_empty;

   // Host push always wins the TX FIFO write port; a colliding echo waits one slot.
   always_comb begin
      tx_push   = host_push;
      tx_din    = tx_data;
      echo_drop = 1'b0;
`ifdef UART_LINK_ECHO_EN
      pend_d      = pend_q;
      pend_data_d = pend_data_q;
      if (host_push) begin
         if (rx_push) begin
            if (pend_q) echo_drop = 1'b1;
            else begin
               pend_d      = 1'b1;
               pend_data_d = rx_sh_q;
            end
         end
      end else if (pend_q) begin
         tx_push = 1'b1;
         tx_din  = pend_data_q;
         pend_d  = rx_push;
         if (rx_push) pend_data_d = rx_sh_q;
      end else if (rx_push) begin
         tx_push = 1'b1;
         tx_din  = rx_sh_q;
      end
`endif
   end

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_sh_d    = tx_sh_q;
      uart_tx_d  = uart_tx_q;
      tx_pop     = 1'b0;
      case (tx_state_q)
         TX_IDLE: begin
            uart_tx_d = 1'b1;
            if (!tx_empty) begin
               tx_pop     = 1'b1;
               tx_sh_d    = tx_fifo_dout;
               tx_cnt_d   = '0;
               uart_tx_d  = 1'b0;
               tx_state_d = TX_START;
            end
         end
         TX_START: begin
            if (tx_cnt_q == CNT_LAST) begin
               tx_cnt_d   = '0;
               tx_bit_d   = '0;
               uart_tx_d  = tx_sh_q[0];
               tx_state_d = TX_DATA;
            end else tx_cnt_d = tx_cnt_q + CNT_W'(1);
         end
         TX_DATA: begin
            if (tx_cnt_q == CNT_LAST) begin
               tx_cnt_d = '0;
               if (tx_bit_q == BIT_LAST) begin
                  uart_tx_d  = 1'b1;
                  tx_state_d = TX_STOP;
               end else begin
                  tx_bit_d  = tx_bit_q + BIT_W'(1);
                  tx_sh_d   = tx_sh_q >> 1;
                  uart_tx_d = tx_sh_q[1];
               end
            end else tx_cnt_d = tx_cnt_q + CNT_W'(1);
         end
         TX_STOP: begin
            if (tx_cnt_q == CNT_LAST) begin
               tx_cnt_d   = '0;
               tx_state_d = TX_IDLE;
            end else tx_cnt_d = tx_cnt_q + CNT_W'(1);
         end
         default: tx_state_d = TX_IDLE;
      endcase
   end

   // Start bit is qualified at mid-bit; every later sample lands DIV clocks apart.
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_sh_d    = rx_sh_q;
      rx_push    = 1'b0;
      rx_ferr    = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            if (!rx_s2_q && rx_prev_q) begin
               rx_cnt_d   = '0;
               rx_state_d = RX_START;
            end
         end
         RX_START: begin
            if (rx_cnt_q == CNT_HALF) begin
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
            end else rx_cnt_d = rx_cnt_q + CNT_W'(1);
         end
         RX_DATA: begin
            if (rx_cnt_q == CNT_LAST) begin
               rx_cnt_d = '0;
               rx_sh_d  = {rx_s2_q, rx_sh_q[DATA_WIDTH-1:1]};
               if (rx_bit_q == BIT_LAST) rx_state_d = RX_STOP;
               else rx_bit_d = rx_bit_q + BIT_W'(1);
            end else rx_cnt_d = rx_cnt_q + CNT_W'(1);
         end
         RX_STOP: begin
            if (rx_cnt_q == CNT_LAST) begin
               rx_cnt_d   = '0;
               rx_state_d = RX_IDLE;
               rx_push    = rx_s2_q;
               rx_ferr    = ~rx_s2_q;
            end else rx_cnt_d = rx_cnt_q + CNT_W'(1);
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   always_comb begin
      tx_overflow_d = (tx_overflow_q & ~clr_err) | echo_drop |
                      (tx_push & ~tx_pop & (tx_count == FC_W'(FIFO_DEPTH)));
      rx_overrun_d  = (rx_overrun_q & ~clr_err) | (rx_push & rx_full & ~rx_pop);
      frame_err_d   = (frame_err_q & ~clr_err) | rx_ferr;
   end

   always_ff @(posedge clk_auto or negedge reset_n) begin
      if (!reset_n) begin
         tx_state_q    <= TX_IDLE;
         rx_state_q    <= RX_IDLE;
         tx_cnt_q      <= '0;
         rx_cnt_q      <= '0;
         tx_bit_q      <= '0;
         rx_bit_q      <= '0;
         uart_tx_q     <= 1'b1;
         send_dly_q    <= 1'b0;
         rx_s1_q       <= 1'b1;
         rx_s2_q       <= 1'b1;
         rx_prev_q     <= 1'b1;
         tx_overflow_q <= 1'b0;
         rx_overrun_q  <= 1'b0;
         frame_err_q   <= 1'b0;
`ifdef UART_LINK_ECHO_EN
         pend_q        <= 1'b0;
`endif
      end else begin
         tx_state_q    <= tx_state_d;
         rx_state_q    <= rx_state_d;
         tx_cnt_q      <= tx_cnt_d;
         rx_cnt_q      <= rx_cnt_d;
         tx_bit_q      <= tx_bit_d;
         rx_bit_q      <= rx_bit_d;
         uart_tx_q     <= uart_tx_d;
         send_dly_q    <= send;
         rx_s1_q       <= UART_RX;
         rx_s2_q       <= rx_s1_q;
         rx_prev_q     <= rx_s2_q;
         tx_overflow_q <= tx_overflow_d;
         rx_overrun_q  <= rx_overrun_d;
         frame_err_q   <= frame_err_d;
`ifdef UART_LINK_ECHO_EN
         pend_q        <= pend_d;
`endif
      end
   end

   always_ff @(posedge clk_auto) begin
      tx_sh_q <= tx_sh_d;
      rx_sh_q <= rx_sh_d;
`ifdef UART_LINK_ECHO_EN
      pend_data_q <= pend_data_d;
`endif
   end

   uart_link_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(clk_auto), .rst_n(reset_n), .push(tx_push), .pop(tx_pop), .din(tx_din),
      .dout(tx_fifo_dout), .full(tx_full), .empty(tx_empty), .count(tx_count)
   );

   uart_link_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(clk_auto), .rst_n(reset_n), .push(rx_push), .pop(rx_pop), .din(rx_sh_q),
      .dout(rx_data), .full(rx_full), .empty(rx_empty), .count(rx_count)
   );

   assign rx_valid    = (rx_count != '0);
   assign tx_overflow = tx_overflow_q;
   assign rx_overrun  = rx_overrun_q;
   assign frame_err   = frame_err_q;
   assign UART_TX     = uart_tx_q;

endmodule
